alu_seq_exec: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALU operation code from the ALU control decoder, plus two operands from the register-read/immediate path.
- Logic, arithmetic and compare operations complete in one cycle.
- Shifts use an iterative one-bit-per-cycle shifter to save area.
- A valid/ready handshake on both sides lets the pipeline stall while a shift is in progress.

---
 rtl/alu_seq_exec.sv | 140 ++++++++++++++
 tb/tb_alu_seq_exec.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare, iterative 1-bit/cycle shifter,
// valid/ready handshake on input and output, with flush and synchronous active-low reset.
module alu_seq_exec #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned SHAMT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_op,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               illegal_op
);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOr   = 4'b0001;
   localparam logic [3:0] OpAdd  = 4'b0010;
   localparam logic [3:0] OpXor  = 4'b0011;
   localparam logic [3:0] OpSll  = 4'b0100;
   localparam logic [3:0] OpSrl  = 4'b0101;
   localparam logic [3:0] OpSub  = 4'b0110;
   localparam logic [3:0] OpSltu = 4'b0111;
   localparam logic [3:0] OpSlt  = 4'b1000;
   localparam logic [3:0] OpSra  = 4'b1001;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 ill_q, ill_d;
   logic [3:0]           op_q, op_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;

   logic [WIDTH-1:0]     alu_res;
   logic                 alu_ill;
   logic                 is_shift;
   logic [SHAMT_W-1:0]   shamt;

   assign shamt    = op_b[SHAMT_W-1:0];
   assign is_shift = (alu_op == OpSll) || (alu_op == OpSrl) || (alu_op == OpSra);

   // Single-cycle datapath for the non-shift operations
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      unique case (alu_op)
         OpAdd:   alu_res = op_a + op_b;
         OpSub:   alu_res = op_a - op_b;
         OpAnd:   alu_res = op_a & op_b;
         OpOr:    alu_res = op_a | op_b;
         OpXor:   alu_res = op_a ^ op_b;
         OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OpSll, OpSrl, OpSra: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      ill_d   = ill_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op_d = alu_op;
                  if (is_shift) begin
                     res_d = op_a;
                     ill_d = 1'b0;
                     if (shamt == '0) begin
                        state_d = StDone;
                     end else begin
                        cnt_d   = shamt;
                        state_d = StShift;
                     end
                  end else begin
                     res_d   = alu_res;
                     ill_d   = alu_ill;
                     state_d = StDone;
                  end
               end
            end
            StShift: begin
               // res_q doubles as the shift register; its MSB still holds op_a's sign for sra
               unique case (op_q)
                  OpSll:   res_d = {res_q[WIDTH-2:0], 1'b0};
                  OpSrl:   res_d = {1'b0, res_q[WIDTH-1:1]};
                  default: res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
               endcase
               cnt_d = cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  state_d = StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         res_q   <= '0;
         ill_q   <= 1'b0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign result     = res_q;
   assign zero       = (res_q == '0);
   assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed scenarios plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_seq_exec;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        zero;
   logic        illegal_op;

   int checks = 0;
   int errors = 0;

   alu_seq_exec #(.WIDTH(64), .SHAMT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .op_a       (op_a),
      .op_b       (op_b),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .illegal_op (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {illegal, result}
   function automatic logic [64:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      int sh;
      sh = int'(b[5:0]);
      case (op)
         4'b0010: return {1'b0, a + b};
         4'b0110: return {1'b0, a - b};
         4'b0000: return {1'b0, a & b};
         4'b0001: return {1'b0, a | b};
         4'b0011: return {1'b0, a ^ b};
         4'b0100: return {1'b0, a << sh};
         4'b0101: return {1'b0, a >> sh};
         4'b1001: return {1'b0, 64'($signed(a) >>> sh)};
         4'b0111: return {1'b0, (a < b) ? 64'd1 : 64'd0};
         4'b1000: return {1'b0, ($signed(a) < $signed(b)) ? 64'd1 : 64'd0};
         default: return {1'b1, 64'd0};
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [63:0] b);
      if ((op == 4'b0100 || op == 4'b0101 || op == 4'b1001) && b[5:0] != 6'd0)
         return int'(b[5:0]) + 1;
      return 1;
   endfunction

   // Presents one op, scrambles inputs after acceptance, waits (bounded) for out_valid.
   task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic il, output logic z,
                         output int lat);
      @(negedge clk);
      alu_op = op; op_a = a; op_b = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; alu_op = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      r = result; il = illegal_op; z = zero;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] r; logic il, z; int lat;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 64'd0 || zero !== 1'b1 || in_ready !== 1'b1 ||
          illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ov=%b res=%h z=%b rdy=%b ill=%b, want 0 0 1 1 0",
                  out_valid, result, zero, in_ready, illegal_op);
      end
      // Mid-shift reset: sll by 40, reset asserted a few cycles in
      @(negedge clk);
      alu_op = 4'b0100; op_a = 64'hDEAD_BEEF_0000_0001; op_b = 64'd40; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 64'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_shift: ov=%b res=%h z=%b rdy=%b, want 0 0 1 1",
                  out_valid, result, zero, in_ready);
      end
      rst_n = 1'b1;
      repeat (45) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_no_resume: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
      run_op(4'b0010, 64'd2, 64'd3, r, il, z, lat);
      checks++;
      if (r !== 64'd5 || lat !== 1) begin
         errors++;
         $display("FAIL reset_then_add: res=%h lat=%0d, want 5 1", r, lat);
      end
      consume();
   endtask

   task automatic test_arith();
      logic [63:0] r; logic il, z; int lat;
      run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, il, z, lat);
      checks++;
      if (r !== 64'h8000_0000_0000_0000 || lat !== 1 || z !== 1'b0) begin
         errors++;
         $display("FAIL add_ovf: res=%h lat=%0d z=%b, want 8000000000000000 1 0", r, lat, z);
      end
      consume();
      run_op(4'b0110, 64'd5, 64'd5, r, il, z, lat);
      checks++;
      if (r !== 64'd0 || z !== 1'b1 || il !== 1'b0) begin
         errors++;
         $display("FAIL sub_zero: res=%h z=%b ill=%b, want 0 1 0", r, z, il);
      end
      consume();
      run_op(4'b0011, 64'hF0F0, 64'h0FF0, r, il, z, lat);
      checks++;
      if (r !== 64'hFF00) begin
         errors++;
         $display("FAIL xor: res=%h, want ff00", r);
      end
      consume();
   endtask

   task automatic test_compare();
      logic [63:0] r; logic il, z; int lat;
      run_op(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, r, il, z, lat);
      checks++;
      if (r !== 64'd1) begin
         errors++;
         $display("FAIL slt_neg: res=%h, want 1", r);
      end
      consume();
      run_op(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, r, il, z, lat);
      checks++;
      if (r !== 64'd0) begin
         errors++;
         $display("FAIL sltu_big: res=%h, want 0", r);
      end
      consume();
      run_op(4'b1000, 64'd3, 64'd3, r, il, z, lat);
      checks++;
      if (r !== 64'd0 || z !== 1'b1) begin
         errors++;
         $display("FAIL slt_eq: res=%h z=%b, want 0 1", r, z);
      end
      consume();
   endtask

   task automatic test_shifts();
      logic [63:0] r; logic il, z; int lat;
      run_op(4'b1001, 64'h8000_0000_0000_0000, 64'd63, r, il, z, lat);
      checks++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 64) begin
         errors++;
         $display("FAIL sra_63: res=%h lat=%0d, want ffffffffffffffff 64", r, lat);
      end
      consume();
      run_op(4'b0101, 64'h8000_0000_0000_0000, 64'd63, r, il, z, lat);
      checks++;
      if (r !== 64'd1 || lat !== 64) begin
         errors++;
         $display("FAIL srl_63: res=%h lat=%0d, want 1 64", r, lat);
      end
      consume();
      run_op(4'b0100, 64'd1, 64'd0, r, il, z, lat);
      checks++;
      if (r !== 64'd1 || lat !== 1) begin
         errors++;
         $display("FAIL sll_0: res=%h lat=%0d, want 1 1", r, lat);
      end
      consume();
      run_op(4'b0100, 64'h0000_0000_0000_0003, 64'h41, r, il, z, lat);
      checks++;
      if (r !== 64'd6 || lat !== 2) begin
         errors++;
         $display("FAIL sll_shamt_mask: res=%h lat=%0d, want 6 2", r, lat);
      end
      consume();
   endtask

   task automatic test_backpressure();
      logic [63:0] r; logic il, z; int lat; int bad;
      run_op(4'b0001, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_5678, r, il, z, lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'h1234_0000_0000_5678)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL backpressure_hold: bad_cycles=%0d, want 0", bad);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_flush();
      int seen;
      @(negedge clk);
      alu_op = 4'b0101; op_a = 64'hFFFF_0000_FFFF_0000; op_b = 64'd20; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL flush_no_result: out_valid_cycles=%0d, want 0", seen);
      end
      alu_op = 4'b0010; op_a = 64'd1; op_b = 64'd1; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_with_valid: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_illegal();
      logic [63:0] r; logic il, z; int lat;
      run_op(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, r, il, z, lat);
      checks++;
      if (r !== 64'd0 || z !== 1'b1 || il !== 1'b1 || lat !== 1) begin
         errors++;
         $display("FAIL illegal: res=%h z=%b ill=%b lat=%0d, want 0 1 1 1", r, z, il, lat);
      end
      consume();
      run_op(4'b0000, 64'hFF, 64'h0F, r, il, z, lat);
      checks++;
      if (r !== 64'h0F || il !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear: res=%h ill=%b, want f 0", r, il);
      end
      consume();
   endtask

   task automatic test_random();
      logic [63:0] r, a, b; logic il, z; int lat; logic [3:0] op; logic [64:0] exp;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         if (i % 4 == 0) b = a;
         exp = ref_alu(op, a, b);
         run_op(op, a, b, r, il, z, lat);
         checks++;
         if (r !== exp[63:0] || il !== exp[64] || z !== (exp[63:0] == 64'd0) ||
             lat !== ref_lat(op, b)) begin
            errors++;
            $display("FAIL random[%0d] op=%b: res=%h ill=%b z=%b lat=%0d, want %h %b %b %0d",
                     i, op, r, il, z, lat, exp[63:0], exp[64], (exp[63:0] == 64'd0),
                     ref_lat(op, b));
         end
         consume();
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; alu_op = 4'd0; op_a = 64'd0; op_b = 64'd0;
      flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_arith();
      test_compare();
      test_shifts();
      test_backpressure();
      test_flush();
      test_illegal();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
